// File: rtl/lane_io_responder_pkg.sv
// Shared constants and FSM encoding for the lane I/O responder and its datapath peers.
package lane_io_responder_pkg;
  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lane_io_responder_if.sv
// Inbound/outbound lane streams between the controller side and the responder.
interface lane_io_responder_if #(
  parameter int LANE_W = lane_io_responder_pkg::LANE_W
);
  logic [LANE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/lane_io_responder_index.sv
// Lane index counter: clears on request, steps per transfer, folds back to 0 after the last lane.
module lane_index_counter #(
  parameter int NUM_LANES = lane_io_responder_pkg::NUM_LANES,
  parameter int IDX_W     = lane_io_responder_pkg::idx_width(NUM_LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);
  assign last = (idx == IDX_W'(NUM_LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc) begin
      idx <= last ? '0 : idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/lane_io_responder.sv
// Moves a NUM_LANES x LANE_W state buffer in (LOAD) or out (STORE) one lane per handshake.
module lane_io_responder #(
  parameter int LANE_W    = lane_io_responder_pkg::LANE_W,
  parameter int NUM_LANES = lane_io_responder_pkg::NUM_LANES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        read_file,
  input  logic                        write_file,
  lane_io_responder_if.slave          io,
  input  logic [LANE_W*NUM_LANES-1:0] state_in,
  output logic [LANE_W*NUM_LANES-1:0] state_out,
  output logic                        load_done,
  output logic                        store_done,
  output logic                        busy
);
  import lane_io_responder_pkg::*;

  localparam int IDX_W = idx_width(NUM_LANES);

  state_t                           state_q, state_d;
  logic [NUM_LANES-1:0][LANE_W-1:0] buf_q;
  logic [IDX_W-1:0]                 idx;
  logic                             last;
  logic                             cnt_clr, capture, load_fin, store_fin;
  logic                             xfer_in, xfer_out;

  assign io.in_ready  = (state_q == ST_LOAD);
  assign io.out_valid = (state_q == ST_STORE);
  assign io.out_data  = buf_q[idx];
  assign busy         = (state_q != ST_IDLE);
  assign state_out    = buf_q;
  assign xfer_in      = io.in_ready & io.in_valid;
  assign xfer_out     = io.out_valid & io.out_ready;

  lane_index_counter #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W)
  ) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clr),
    .inc   (xfer_in | xfer_out),
    .idx   (idx),
    .last  (last)
  );

  // Requests are only looked at in IDLE; a simultaneous read beats the write.
  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    capture   = 1'b0;
    load_fin  = 1'b0;
    store_fin = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (read_file) begin
          state_d = ST_LOAD;
          cnt_clr = 1'b1;
        end else if (write_file) begin
          state_d = ST_STORE;
          cnt_clr = 1'b1;
          capture = 1'b1;
        end
      end
      ST_LOAD: begin
        if (xfer_in && last) begin
          state_d  = ST_IDLE;
          load_fin = 1'b1;
        end
      end
      ST_STORE: begin
        if (xfer_out && last) begin
          state_d   = ST_IDLE;
          store_fin = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      load_done  <= 1'b0;
      store_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_done  <= load_fin;
      store_done <= store_fin;
    end
  end

  // Buffer is cleared on reset so an aborted load leaves no partial data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (capture) begin
      buf_q <= state_in;
    end else if (xfer_in) begin
      buf_q[idx] <= io.in_data;
    end
  end
endmodule
